// File: rtl/video_frame_sig.sv
// video_frame_sig: per-frame signature of a CE-qualified video stream.
// Folds every active pixel of a frame into an MSB-first CRC and measures the
// line geometry. On each VS rise it reports CRC, pixels per line, active
// line count and a line-length consistency flag, together with a one-cycle
// VALID strobe.
module video_frame_sig #(
  parameter int              NCH  = 3,
  parameter int              CW   = 8,
  parameter int              CRCW = 32,
  parameter logic [CRCW-1:0] POLY = CRCW'(32'h04C11DB7),
  parameter int              XW   = 12
) (
  input  logic                CLK,
  input  logic                RESB,
  input  logic                CE,
  input  logic                DE,
  input  logic                HS,
  input  logic                VS,
  input  logic [NCH*CW-1:0]   RGB,
  input  logic [NCH-1:0]      CH_MASK,
  output logic [CRCW-1:0]     SIG,
  output logic [XW-1:0]       PPL,
  output logic [XW-1:0]       LINES,
  output logic [XW-1:0]       FRAMES,
  output logic                LEN_ERR,
  output logic                VALID
);

  localparam int DW = NCH * CW;

  typedef enum logic {SYNC = 1'b0, RUN = 1'b1} state_t;

  // Fold one data word into the CRC, MSB first, non-reflected.
  function automatic logic [CRCW-1:0] crc_fold(input logic [CRCW-1:0] crc,
                                               input logic [DW-1:0]   d);
    logic [CRCW-1:0] c;
    logic            fb;
    c = crc;
    for (int i = DW - 1; i >= 0; i--) begin
      fb = c[CRCW-1] ^ d[i];
      c  = {c[CRCW-2:0], 1'b0};
      if (fb) c = c ^ POLY;
    end
    return c;
  endfunction

  // Increment that sticks at all ones instead of wrapping.
  function automatic logic [XW-1:0] sat_inc(input logic [XW-1:0] x);
    return (&x) ? x : x + 1'b1;
  endfunction

  state_t          state_q, state_d;
  logic            de_prev, vs_prev;
  logic            vs_rise, de_fall;
  logic            run_pix, eol, frame_end;
  logic [DW-1:0]   word;

  logic [CRCW-1:0] crc_acc;
  logic [XW-1:0]   pix_acc, lines_acc, ref_acc;
  logic            ref_set_acc, err_acc;

  logic [CRCW-1:0] crc_n;
  logic [XW-1:0]   pix_n, pix_after, lines_n, ref_n;
  logic            ref_set_n, err_n;

  // HS carries no accounting meaning; lines are delimited by DE alone.
  logic            hs_unused;
  assign hs_unused = HS;

  // Edge detection against the previous CE-qualified samples.
  assign vs_rise = CE & VS & ~vs_prev;
  assign de_fall = CE & ~DE & de_prev;

  // Apply the per-channel mask to the incoming pixel.
  always_comb begin
    word = '0;
    for (int ch = 0; ch < NCH; ch++) begin
      word[ch*CW +: CW] = CH_MASK[ch] ? RGB[ch*CW +: CW] : '0;
    end
  end

  // State register: SYNC until the first VS rise, then RUN until reset.
  always_ff @(posedge CLK) begin
    if (!RESB) state_q <= SYNC;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    if (state_q == SYNC && vs_rise) state_d = RUN;
  end

  // FSM output decode: which accounting events happen on this cycle.
  // A line still open at VS is closed as part of the frame end.
  always_comb begin
    run_pix   = 1'b0;
    eol       = 1'b0;
    frame_end = 1'b0;
    if (state_q == RUN) begin
      run_pix   = CE & DE;
      eol       = de_fall | (vs_rise & de_prev);
      frame_end = vs_rise;
    end
  end

  // Next accumulator values: pixel fold first, then end-of-line bookkeeping.
  always_comb begin
    crc_n     = run_pix ? crc_fold(crc_acc, word) : crc_acc;
    pix_n     = run_pix ? sat_inc(pix_acc) : pix_acc;
    lines_n   = lines_acc;
    ref_n     = ref_acc;
    ref_set_n = ref_set_acc;
    err_n     = err_acc;
    pix_after = pix_n;
    if (eol) begin
      lines_n   = sat_inc(lines_acc);
      pix_after = '0;
      if (!ref_set_acc) begin
        ref_n     = pix_n;
        ref_set_n = 1'b1;
      end else if (pix_n != ref_acc) begin
        err_n = 1'b1;
      end
    end
  end

  // Previous DE/VS samples advance only on CE.
  always_ff @(posedge CLK) begin
    if (!RESB) begin
      de_prev <= 1'b0;
      vs_prev <= 1'b0;
    end else if (CE) begin
      de_prev <= DE;
      vs_prev <= VS;
    end
  end

  // Stage 0 -> accumulators: reinitialised on every VS rise, otherwise
  // advanced; contents are meaningless until the first VS rise.
  always_ff @(posedge CLK) begin
    if (vs_rise) begin
      crc_acc     <= '1;
      pix_acc     <= '0;
      lines_acc   <= '0;
      ref_acc     <= '0;
      ref_set_acc <= 1'b0;
      err_acc     <= 1'b0;
    end else begin
      crc_acc     <= crc_n;
      pix_acc     <= pix_after;
      lines_acc   <= lines_n;
      ref_acc     <= ref_n;
      ref_set_acc <= ref_set_n;
      err_acc     <= err_n;
    end
  end

  // Stage 1 -> result registers: latch the closing frame's values.
  always_ff @(posedge CLK) begin
    if (!RESB) begin
      SIG     <= '0;
      PPL     <= '0;
      LINES   <= '0;
      FRAMES  <= '0;
      LEN_ERR <= 1'b0;
      VALID   <= 1'b0;
    end else begin
      VALID <= frame_end;
      if (frame_end) begin
        SIG     <= crc_n;
        PPL     <= ref_set_n ? ref_n : '0;
        LINES   <= lines_n;
        LEN_ERR <= err_n;
        FRAMES  <= FRAMES + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_video_frame_sig.sv
// Testbench for video_frame_sig: a frame-level model built from queues of
// pixel words and line lengths, a per-cycle compare against the default
// instance, and literal expectations for the directed scenarios.
module tb_video_frame_sig;

  logic        CLK = 1'b0;
  logic        RESB, CE, DE, HS, VS;
  logic [23:0] RGB;
  logic [2:0]  CH_MASK;

  logic [31:0] SIG;
  logic [11:0] PPL, LINES, FRAMES;
  logic        LEN_ERR, VALID;

  logic [31:0] SIG1;
  logic [11:0] PPL1, LINES1, FRAMES1;
  logic        LEN_ERR1, VALID1;

  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  video_frame_sig u_dut (
    .CLK(CLK), .RESB(RESB), .CE(CE), .DE(DE), .HS(HS), .VS(VS),
    .RGB(RGB), .CH_MASK(CH_MASK),
    .SIG(SIG), .PPL(PPL), .LINES(LINES), .FRAMES(FRAMES),
    .LEN_ERR(LEN_ERR), .VALID(VALID)
  );

  video_frame_sig #(.NCH(1), .CW(8)) u_dut1 (
    .CLK(CLK), .RESB(RESB), .CE(CE), .DE(DE), .HS(HS), .VS(VS),
    .RGB(RGB[7:0]), .CH_MASK(CH_MASK[0:0]),
    .SIG(SIG1), .PPL(PPL1), .LINES(LINES1), .FRAMES(FRAMES1),
    .LEN_ERR(LEN_ERR1), .VALID(VALID1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // CRC of a whole frame's word list, each word w bits wide, MSB first.
  function automatic logic [31:0] crc_of(input logic [23:0] q[$], input int w);
    logic [31:0] c;
    bit          fb;
    c = 32'hFFFF_FFFF;
    for (int k = 0; k < q.size(); k++) begin
      for (int b = w - 1; b >= 0; b--) begin
        fb = c[31] ^ q[k][b];
        c  = c << 1;
        if (fb) c = c ^ 32'h04C11DB7;
      end
    end
    return c;
  endfunction

  // Frame-level model of the default instance.
  logic [23:0] m_words[$];
  int          m_lens[$];
  int          m_cur = 0;
  bit          m_sync = 1, m_pde = 0, m_pvs = 0;
  logic [31:0] e_sig = 0;
  int          e_ppl = 0, e_lines = 0, e_frames = 0;
  bit          e_err = 0, e_valid = 0;

  always @(posedge CLK) begin
    bit rise, fall;
    logic [23:0] w;
    e_valid = 0;
    if (!RESB) begin
      m_sync = 1; m_pde = 0; m_pvs = 0;
      e_sig = 0; e_ppl = 0; e_lines = 0; e_frames = 0; e_err = 0;
    end else if (CE) begin
      rise = VS && !m_pvs;
      fall = !DE && m_pde;
      if (m_sync) begin
        if (rise) begin
          m_sync = 0; m_words.delete(); m_lens.delete(); m_cur = 0;
        end
      end else begin
        if (DE) begin
          for (int ch = 0; ch < 3; ch++)
            w[ch*8 +: 8] = CH_MASK[ch] ? RGB[ch*8 +: 8] : 8'h00;
          m_words.push_back(w);
          m_cur++;
        end
        if (fall || (rise && m_pde)) begin
          m_lens.push_back(m_cur);
          m_cur = 0;
        end
        if (rise) begin
          e_sig   = crc_of(m_words, 24);
          e_ppl   = (m_lens.size() > 0) ? m_lens[0] : 0;
          e_lines = m_lens.size();
          e_err   = 0;
          foreach (m_lens[i]) if (m_lens[i] != m_lens[0]) e_err = 1;
          e_frames = (e_frames + 1) % 4096;
          e_valid  = 1;
          m_words.delete(); m_lens.delete(); m_cur = 0;
        end
      end
      m_pde = DE;
      m_pvs = VS;
    end
  end

  // Per-cycle compare of every result output against the model.
  always @(posedge CLK) begin
    #1;
    check("VALID",   32'(VALID),   32'(e_valid));
    check("SIG",     SIG,          e_sig);
    check("PPL",     32'(PPL),     32'(e_ppl));
    check("LINES",   32'(LINES),   32'(e_lines));
    check("FRAMES",  32'(FRAMES),  32'(e_frames));
    check("LEN_ERR", 32'(LEN_ERR), 32'(e_err));
  end

  task automatic step(input bit ce, input bit de, input bit vs, input logic [23:0] rgb);
    @(negedge CLK);
    CE = ce; DE = de; VS = vs; RGB = rgb; HS = ~de;
  endtask

  task automatic vs_pulse();
    step(1, 0, 1, 24'h0);
    step(1, 0, 0, 24'h0);
  endtask

  task automatic line(input int n, input int seed);
    for (int i = 0; i < n; i++)
      step(1, 1, 0, {8'(i), 8'(seed), 8'(i * 5 + seed)});
    step(1, 0, 0, 24'h0);
  endtask

  task automatic gapped_line(input int n);
    for (int i = 0; i < n; i++) begin
      step(0, 1'($urandom), 1'($urandom), 24'($urandom));
      step(0, 1'($urandom), 1'($urandom), 24'($urandom));
      step(1, 1, 0, 24'(i * 37 + 11));
    end
    step(0, 1, 1, 24'hABCDEF);
    step(1, 0, 0, 24'h0);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RESB = 0; CE = 1; DE = 0; VS = 0;
    @(negedge CLK);
    RESB = 1;
  endtask

  logic [23:0] pin_q[$];
  logic [31:0] sig_a;

  initial begin
    RESB = 0; CE = 0; DE = 0; HS = 0; VS = 0; RGB = 0; CH_MASK = 3'b111;
    repeat (3) @(negedge CLK);
    RESB = 1;

    // Reset state and model pin on the standard CRC check string.
    check("rst_SIG", SIG, 32'h0);
    check("rst_FRAMES", 32'(FRAMES), 32'h0);
    check("rst_VALID1", 32'(VALID1), 32'h0);
    for (int i = 0; i < 9; i++) pin_q.push_back(24'h31 + 24'(i));
    check("model_pin", crc_of(pin_q, 8), 32'h0376E6E7);

    // Single-channel instance: "123456789" as one line.
    vs_pulse();
    for (int i = 0; i < 9; i++) step(1, 1, 0, 24'h31 + 24'(i));
    step(1, 0, 0, 24'h0);
    step(1, 0, 1, 24'h0);
    step(1, 0, 0, 24'h0);
    check("t1_VALID1", 32'(VALID1), 32'h1);
    check("t1_SIG1", SIG1, 32'h0376E6E7);
    check("t1_PPL1", 32'(PPL1), 32'd9);
    check("t1_LINES1", 32'(LINES1), 32'd1);
    check("t1_LENERR1", 32'(LEN_ERR1), 32'd0);
    check("t1_FRAMES1", 32'(FRAMES1), 32'd1);
    step(1, 0, 0, 24'h0);
    check("t1_VALID1_off", 32'(VALID1), 32'h0);

    // Pre-sync pixels are discarded; an empty frame reports the CRC seed.
    do_reset();
    line(5, 3);
    vs_pulse();
    vs_pulse();
    check("t2_SIG", SIG, 32'hFFFF_FFFF);
    check("t2_PPL", 32'(PPL), 32'd0);
    check("t2_LINES", 32'(LINES), 32'd0);
    check("t2_FRAMES", 32'(FRAMES), 32'd1);

    // Inconsistent last line, then a clean frame.
    for (int l = 0; l < 4; l++) line(256, l);
    line(255, 9);
    vs_pulse();
    check("t3_PPL", 32'(PPL), 32'd256);
    check("t3_LINES", 32'(LINES), 32'd5);
    check("t3_LENERR", 32'(LEN_ERR), 32'd1);
    for (int l = 0; l < 4; l++) line(256, l);
    vs_pulse();
    check("t3b_PPL", 32'(PPL), 32'd256);
    check("t3b_LINES", 32'(LINES), 32'd4);
    check("t3b_LENERR", 32'(LEN_ERR), 32'd0);

    // Fully masked random data matches unmasked zero data.
    CH_MASK = 3'b000;
    for (int l = 0; l < 3; l++) begin
      for (int i = 0; i < 6; i++) step(1, 1, 0, 24'($urandom));
      step(1, 0, 0, 24'h0);
    end
    vs_pulse();
    sig_a = SIG;
    CH_MASK = 3'b111;
    for (int l = 0; l < 3; l++) begin
      for (int i = 0; i < 6; i++) step(1, 1, 0, 24'h0);
      step(1, 0, 0, 24'h0);
    end
    vs_pulse();
    check("t4_mask_sig", SIG, sig_a);

    // VS rise on the last pixel of an open line.
    line(4, 1);
    line(4, 2);
    for (int i = 0; i < 3; i++) step(1, 1, 0, 24'(i + 100));
    step(1, 1, 1, 24'h0000FF);
    step(1, 0, 1, 24'h0);
    step(1, 0, 0, 24'h0);
    check("t5_LINES", 32'(LINES), 32'd3);
    check("t5_PPL", 32'(PPL), 32'd4);
    check("t5_LENERR", 32'(LEN_ERR), 32'd0);

    // Mid-frame reset, then CE-gated traffic.
    for (int i = 0; i < 3; i++) step(1, 1, 0, 24'(i));
    do_reset();
    check("t6_SIG", SIG, 32'h0);
    check("t6_LINES", 32'(LINES), 32'h0);
    check("t6_FRAMES", 32'(FRAMES), 32'h0);
    for (int i = 0; i < 3; i++) step(0, 1, 1, 24'($urandom));
    step(1, 0, 0, 24'h0);
    gapped_line(5);
    vs_pulse();
    check("t6_no_report", 32'(FRAMES), 32'h0);
    gapped_line(5);
    gapped_line(5);
    vs_pulse();
    check("t6b_FRAMES", 32'(FRAMES), 32'd1);
    check("t6b_LINES", 32'(LINES), 32'd2);
    check("t6b_PPL", 32'(PPL), 32'd5);
    repeat (4) step(1, 0, 0, 24'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
